// File: rtl/nlc_pkg.sv
// Shared constants and state encoding for the NLC result collector.
package nlc_pkg;

   localparam int unsigned NUM_CH = 16;
   localparam int unsigned DW     = 21;
   localparam int unsigned CH_W   = 4;
   localparam int unsigned CNT_W  = $clog2(NUM_CH + 1);

   typedef enum logic [1:0] {
      StIdle    = 2'b00,
      StCollect = 2'b01,
      StCommit  = 2'b10
   } state_e;

endpackage

// File: rtl/nlc_capture_bank.sv
// Shadow register file and capture mask for one frame under collection.
module nlc_capture_bank
   import nlc_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clr,
   input  logic                 wr_en,
   input  logic [CH_W-1:0]      ch,
   input  logic [DW-1:0]        wr_data,
   output logic                 hit,
   output logic                 full,
   output logic [NUM_CH*DW-1:0] shadow
);

   logic [NUM_CH-1:0]    mask_q, mask_d;
   logic [NUM_CH*DW-1:0] data_q;

   // Clear and write may coincide: the write lands in the freshly cleared mask.
   always_comb begin
      mask_d = clr ? '0 : mask_q;
      if (wr_en) mask_d[ch] = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mask_q <= '0;
         data_q <= '0;
      end else begin
         mask_q <= mask_d;
         if (wr_en) data_q[ch*DW +: DW] <= wr_data;
      end
   end

   assign hit    = mask_q[ch];
   assign full   = &mask_d;
   assign shadow = data_q;

endmodule

// File: rtl/nlc_result_collector.sv
// Assembles per-channel converter results into a 16-channel frame and publishes it
// atomically; double-buffered so the published frame is stable during collection.
module nlc_result_collector
   import nlc_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 frame_start_i,
   input  logic                 res_vld_i,
   input  logic [CH_W-1:0]      res_ch_i,
   input  logic [DW-1:0]        res_data_i,
   output logic [NUM_CH*DW-1:0] x_lin_o,
   output logic                 srdyo,
   output logic                 busy_o,
   output logic [CNT_W-1:0]     count_o,
   output logic                 dup_err_o,
   output logic                 ovf_err_o,
   output logic                 abort_err_o,
   input  logic                 err_clr_i
);

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     count_q, count_d;
   logic                 bank_clr, bank_wr, hit, full, ch_ok;
   logic                 set_dup, set_ovf, set_abort;
   logic                 dup_q, ovf_q, abort_q;
   logic                 srdy_q;
   logic [NUM_CH*DW-1:0] shadow, x_lin_q;

   assign ch_ok = 32'(res_ch_i) < NUM_CH;

   nlc_capture_bank u_bank (
      .clk     (clk),
      .reset   (reset),
      .clr     (bank_clr),
      .wr_en   (bank_wr),
      .ch      (res_ch_i),
      .wr_data (res_data_i),
      .hit     (hit),
      .full    (full),
      .shadow  (shadow)
   );

   // Capture strobes and error events; kept apart from next-state to avoid a comb loop
   // through the bank's full flag.
   always_comb begin
      bank_clr  = 1'b0;
      bank_wr   = 1'b0;
      set_dup   = 1'b0;
      set_ovf   = 1'b0;
      set_abort = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (frame_start_i) begin
               bank_clr = 1'b1;
               bank_wr  = res_vld_i && ch_ok;
               set_dup  = res_vld_i && !ch_ok;
            end else begin
               set_ovf  = res_vld_i;
            end
         end
         StCollect: begin
            if (frame_start_i) begin
               bank_clr  = 1'b1;
               bank_wr   = res_vld_i && ch_ok;
               set_dup   = res_vld_i && !ch_ok;
               set_abort = 1'b1;
            end else begin
               bank_wr = res_vld_i && ch_ok && !hit;
               set_dup = res_vld_i && (!ch_ok || hit);
            end
         end
         StCommit: begin
            bank_clr = 1'b1;
            set_ovf  = res_vld_i;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:    if (frame_start_i) state_d = StCollect;
         StCollect: if (!frame_start_i && full) state_d = StCommit;
         StCommit:  state_d = frame_start_i ? StCollect : StIdle;
         default:   state_d = StIdle;
      endcase
      count_d = bank_clr ? '0 : count_q;
      if (bank_wr) count_d = count_d + CNT_W'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         count_q <= '0;
         x_lin_q <= '0;
         srdy_q  <= 1'b0;
         dup_q   <= 1'b0;
         ovf_q   <= 1'b0;
         abort_q <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         srdy_q  <= (state_q == StCommit);
         if (state_q == StCommit) x_lin_q <= shadow;
         dup_q   <= (dup_q && !err_clr_i) || set_dup;
         ovf_q   <= (ovf_q && !err_clr_i) || set_ovf;
         abort_q <= (abort_q && !err_clr_i) || set_abort;
      end
   end

   assign x_lin_o     = x_lin_q;
   assign srdyo       = srdy_q;
   assign busy_o      = (state_q != StIdle);
   assign count_o     = count_q;
   assign dup_err_o   = dup_q;
   assign ovf_err_o   = ovf_q;
   assign abort_err_o = abort_q;

endmodule

// File: tb/tb_nlc_result_collector.sv
// Directed bench for nlc_result_collector: hand-written frame sequences plus a vector table.
module tb_nlc_result_collector;
   import nlc_pkg::*;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 frame_start_i, res_vld_i, err_clr_i;
   logic [CH_W-1:0]      res_ch_i;
   logic [DW-1:0]        res_data_i;
   logic [NUM_CH*DW-1:0] x_lin_o;
   logic                 srdyo, busy_o, dup_err_o, ovf_err_o, abort_err_o;
   logic [CNT_W-1:0]     count_o;

   int checks = 0;
   int errors = 0;

   nlc_result_collector dut (
      .clk           (clk),
      .reset         (reset),
      .frame_start_i (frame_start_i),
      .res_vld_i     (res_vld_i),
      .res_ch_i      (res_ch_i),
      .res_data_i    (res_data_i),
      .x_lin_o       (x_lin_o),
      .srdyo         (srdyo),
      .busy_o        (busy_o),
      .count_o       (count_o),
      .dup_err_o     (dup_err_o),
      .ovf_err_o     (ovf_err_o),
      .abort_err_o   (abort_err_o),
      .err_clr_i     (err_clr_i)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic            fs, vld, clr;
      logic [CH_W-1:0] ch;
      logic [DW-1:0]   data;
      int              cnt;
      logic            srdy, busy, dup, ovf, abt;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_frame(input string name, input logic [NUM_CH*DW-1:0] exp);
      checks++;
      if (x_lin_o !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, x_lin_o, exp);
      end
   endtask

   function automatic logic [NUM_CH*DW-1:0] mk_frame(input logic [DW-1:0] base);
      logic [NUM_CH*DW-1:0] f;
      for (int n = 0; n < NUM_CH; n++) f[n*DW +: DW] = base + DW'(n);
      return f;
   endfunction

   // Apply inputs at negedge, return 1 time unit after the following posedge.
   task automatic drive(input logic fs, input logic vld, input logic [CH_W-1:0] ch,
                        input logic [DW-1:0] d, input logic clr);
      @(negedge clk);
      frame_start_i = fs;
      res_vld_i     = vld;
      res_ch_i      = ch;
      res_data_i    = d;
      err_clr_i     = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, '0, '0, 1'b0);
   endtask

   task automatic send_one(input int ch, input logic [DW-1:0] d, input int exp_cnt);
      drive(1'b0, 1'b1, CH_W'(ch), d, 1'b0);
      chk("send_srdyo", srdyo, 0);
      chk("send_count", count_o, 64'(exp_cnt));
   endtask

   // Sends ch0..15 (frame already open), then checks commit timing and contents.
   task automatic send_frame(input logic [DW-1:0] base, input logic fs_at_commit);
      for (int i = 0; i < NUM_CH; i++) send_one(i, base + DW'(i), i + 1);
      chk("frame_busy_commit", busy_o, 1);
      drive(fs_at_commit, 1'b0, '0, '0, 1'b0);
      chk("frame_srdyo_pulse", srdyo, 1);
      chk_frame("frame_data", mk_frame(base));
      chk("frame_count_after", count_o, 0);
      chk("frame_busy_after", busy_o, 64'(fs_at_commit));
      if (!fs_at_commit) begin
         idle();
         chk("frame_srdyo_drop", srdyo, 0);
         chk("frame_busy_idle", busy_o, 0);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [NUM_CH*DW-1:0] f4;
      vec_t vt[10];

      reset = 1'b1;
      frame_start_i = 1'b0; res_vld_i = 1'b0; err_clr_i = 1'b0;
      res_ch_i = '0; res_data_i = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;
      chk_frame("rst_xlin", '0);
      chk("rst_srdyo", srdyo, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_count", count_o, 0);
      chk("rst_errs", {dup_err_o, ovf_err_o, abort_err_o}, 0);

      // In-order frame on consecutive cycles.
      drive(1'b1, 1'b0, '0, '0, 1'b0);
      chk("t2_busy", busy_o, 1);
      send_frame(21'h100000, 1'b0);
      chk("t2_errs", {dup_err_o, ovf_err_o, abort_err_o}, 0);

      // Reverse order with 3-cycle gaps.
      drive(1'b1, 1'b0, '0, '0, 1'b0);
      for (int i = 0; i < NUM_CH; i++) begin
         send_one(15 - i, 21'h100000 + DW'(15 - i), i + 1);
         for (int g = 0; g < 3; g++) begin
            idle();
            if (i == NUM_CH - 1 && g == 0) begin
               chk("t3_srdyo", srdyo, 1);
               chk("t3_count0", count_o, 0);
               chk_frame("t3_frame", mk_frame(21'h100000));
            end else begin
               chk("t3_nosrdy", srdyo, 0);
            end
         end
      end

      // Duplicate channel 5: first value kept.
      drive(1'b1, 1'b0, '0, '0, 1'b0);
      for (int c = 0; c < 5; c++) send_one(c, 21'h100000 + DW'(c), c + 1);
      send_one(5, 21'h0AAAAA, 6);
      chk("t4_dup_pre", dup_err_o, 0);
      send_one(5, 21'h155555, 6);
      chk("t4_dup", dup_err_o, 1);
      for (int c = 6; c < NUM_CH; c++) send_one(c, 21'h100000 + DW'(c), c + 1);
      idle();
      f4 = mk_frame(21'h100000);
      f4[5*DW +: DW] = 21'h0AAAAA;
      chk("t4_srdyo", srdyo, 1);
      chk_frame("t4_frame", f4);
      drive(1'b0, 1'b0, '0, '0, 1'b1);
      chk("t4_dup_clr", dup_err_o, 0);

      // Abort a partial frame, then a full frame.
      drive(1'b1, 1'b0, '0, '0, 1'b0);
      for (int c = 0; c < 10; c++) send_one(c, 21'h050000 + DW'(c), c + 1);
      drive(1'b1, 1'b0, '0, '0, 1'b0);
      chk("t6_abort", abort_err_o, 1);
      chk("t6_abort_cnt", count_o, 0);
      chk("t6_abort_srdyo", srdyo, 0);
      chk("t6_abort_busy", busy_o, 1);
      chk_frame("t6_abort_xlin", f4);
      send_frame(21'h0C0000, 1'b0);
      drive(1'b0, 1'b0, '0, '0, 1'b1);
      chk("t6_abort_clr", abort_err_o, 0);

      // frame_start in the COMMIT cycle: back-to-back frames.
      drive(1'b1, 1'b0, '0, '0, 1'b0);
      send_frame(21'h011000, 1'b1);
      send_frame(21'h022000, 1'b0);
      chk("t6_b2b_errs", {dup_err_o, ovf_err_o, abort_err_o}, 0);

      // Asynchronous reset mid-collection.
      drive(1'b1, 1'b0, '0, '0, 1'b0);
      for (int c = 0; c < 7; c++) send_one(c, 21'h077000 + DW'(c), c + 1);
      @(negedge clk);
      frame_start_i = 1'b0; res_vld_i = 1'b0;
      #2 reset = 1'b1;
      #1;
      chk_frame("t1_rst_xlin", '0);
      chk("t1_rst_srdyo", srdyo, 0);
      chk("t1_rst_count", count_o, 0);
      chk("t1_rst_busy", busy_o, 0);
      @(negedge clk);
      reset = 1'b0;
      drive(1'b1, 1'b0, '0, '0, 1'b0);
      send_frame(21'h1A0000, 1'b0);

      //         fs    vld   clr   ch     data         cnt srdy  busy  dup   ovf   abt
      vt[0] = '{1'b0, 1'b1, 1'b0, 4'd3, 21'h1FFFFF, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      vt[1] = '{1'b0, 1'b0, 1'b1, 4'd0, 21'h000000, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vt[2] = '{1'b1, 1'b1, 1'b0, 4'd2, 21'h000022, 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      vt[3] = '{1'b0, 1'b1, 1'b0, 4'd2, 21'h000033, 1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      vt[4] = '{1'b0, 1'b1, 1'b1, 4'd2, 21'h000044, 1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      vt[5] = '{1'b0, 1'b0, 1'b1, 4'd0, 21'h000000, 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      vt[6] = '{1'b1, 1'b0, 1'b0, 4'd0, 21'h000000, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      vt[7] = '{1'b1, 1'b1, 1'b0, 4'd7, 21'h000077, 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      vt[8] = '{1'b0, 1'b1, 1'b1, 4'd8, 21'h000088, 2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      vt[9] = '{1'b0, 1'b1, 1'b0, 4'd9, 21'h000099, 3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      for (int i = 0; i < 10; i++) begin
         drive(vt[i].fs, vt[i].vld, vt[i].ch, vt[i].data, vt[i].clr);
         chk($sformatf("vec%0d_count", i), count_o, 64'(vt[i].cnt));
         chk($sformatf("vec%0d_srdyo", i), srdyo, vt[i].srdy);
         chk($sformatf("vec%0d_busy", i), busy_o, vt[i].busy);
         chk($sformatf("vec%0d_dup", i), dup_err_o, vt[i].dup);
         chk($sformatf("vec%0d_ovf", i), ovf_err_o, vt[i].ovf);
         chk($sformatf("vec%0d_abort", i), abort_err_o, vt[i].abt);
      end
      chk_frame("vec_xlin_stable", mk_frame(21'h1A0000));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/nlc_result_collector.md
Name: nlc_result_collector

Overview:
Downstream stage of the shared-datapath NLC top. It takes the serialized 21-bit fixed-point results from the shared smc-float-to-fp converter, one channel at a time and tagged with a channel index, and assembles them into a complete 16-channel frame. When the frame is complete it publishes all 16 results at once on registered ch*_x_lin outputs and pulses srdyo. Collection is double-buffered, so the published frame stays stable while the next frame accumulates.

Parameters:
NUM_CH, 16, number of channels per frame (index width = clog2(NUM_CH))
DW, 21, fixed-point result width
CH_W, 4, channel tag width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
frame_start_i  in  1  one-cycle pulse from controller when srdyi is accepted; opens a new frame
res_vld_i  in  1  result valid from fp converter (its srdyo)
res_ch_i  in  CH_W  channel index of result, 0..NUM_CH-1
res_data_i  in  DW  converted x_lin value
x_lin_o  out  NUM_CH*DW  published frame; channel n occupies bits [n*DW +: DW]
srdyo  out  1  one-cycle pulse: new frame published
busy_o  out  1  high in COLLECT or COMMIT
count_o  out  5  number of distinct channels captured in current frame
dup_err_o  out  1  sticky: same channel delivered twice within a frame
ovf_err_o  out  1  sticky: result arrived with no open frame
abort_err_o  out  1  sticky: frame_start_i arrived while a frame was incomplete
err_clr_i  in  1  synchronous clear of all three sticky errors

Behaviour:
- Reset (async, immediate): state=IDLE; x_lin_o=0; srdyo=0; busy_o=0; count_o=0; shadow regs=0; capture mask=0; all errors=0.
- FSM states: IDLE, COLLECT, COMMIT.
- IDLE:
  - frame_start_i: clear mask and count, go to COLLECT.
  - If res_vld_i is high on the same cycle as frame_start_i, the result is written into the new frame.
  - res_vld_i without frame_start_i: result dropped, ovf_err_o set.
- COLLECT, on res_vld_i:
  - mask[ch]==0: write shadow[ch], set mask[ch], count+1.
  - mask[ch]==1: result dropped (first value kept), dup_err_o set.
  - res_ch_i >= NUM_CH: dropped, dup_err_o set.
- COLLECT to COMMIT: on the edge where the mask becomes all-ones.
- COMMIT (exactly one cycle):
  - The edge leaving COMMIT loads x_lin_o from the shadow regs and asserts srdyo for one cycle.
  - Latency: 16th result captured at edge k; x_lin_o updates and srdyo=1 after edge k+1; srdyo=0 after edge k+2.
  - res_vld_i during COMMIT: dropped, ovf_err_o set.
  - frame_start_i during COMMIT: commit still completes, next state is COLLECT with mask cleared; otherwise next state is IDLE.
- frame_start_i in COLLECT (partial frame):
  - Partial frame discarded, mask and count cleared, stay in COLLECT, abort_err_o set.
  - x_lin_o is not updated and srdyo is not pulsed.
  - A simultaneous res_vld_i goes into the new frame.
- x_lin_o changes only on commit and on reset.
- Shadow contents are not cleared between frames; the mask alone gates completion.
- err_clr_i: clears errors at the next edge. If an error event coincides with err_clr_i, the set wins.
- Arithmetic: data passes through unmodified, no saturation. count_o is 0..16.

Decomposition:
- Shared package nlc_pkg:
  - NUM_CH, DW, CH_W constants.
  - State enum encoding: IDLE=2'b00, COLLECT=2'b01, COMMIT=2'b10.
- Sub-module nlc_capture_bank: NUM_CH x DW shadow register file plus capture mask with write, clear and all-full outputs. The FSM, errors and output regs stay in the top of this block.

Test Plan:
1. Reset mid-COLLECT after 7 results -> on the reset edge: x_lin_o=0, srdyo=0, count_o=0, busy_o=0; a following full frame commits normally.
2. frame_start, then results ch0..ch15 with data 0x100000+ch on consecutive cycles -> srdyo high exactly one cycle, 2 edges after ch15; x_lin_o[n*21 +: 21]=0x100000+n; no errors.
3. Results in reverse order ch15..ch0 with gaps of 3 idle cycles -> same frame published; count_o steps 1..16, then 0 after commit.
4. ch5 sent twice (0x0AAAAA, then 0x155555) within a frame -> dup_err_o=1; published ch5=0x0AAAAA; the frame still completes after the remaining channels.
5. res_vld_i in IDLE (ch3, 0x1FFFFF) -> ovf_err_o=1, x_lin_o unchanged. Then err_clr_i -> ovf_err_o=0.
6. frame_start after 10 results, then a full 16-result frame; separately, frame_start asserted in the COMMIT cycle -> abort_err_o=1 with no publish of the partial frame; the back-to-back case gives two srdyo pulses with the second frame correct.
